// File: rtl/booth_seq_controller.sv
// rtl/booth_seq_controller.sv - sequencing FSM for the iterative radix-2/radix-4 Booth multiplier datapath
module booth_seq_controller #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             radix4,
    input  logic             abort,
    input  logic             out_ready,
    output logic             start_ack,
    output logic             load_en,
    output logic             step_en,
    output logic             first_round,
    output logic             last_round,
    output logic [CNT_W-1:0] iter_idx,
    output logic             mode_r4,
    output logic             busy,
    output logic             out_valid
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Final counter value per recoding mode: radix-2 takes WIDTH steps,
    // radix-4 consumes two multiplier bits per step.
    localparam logic [CNT_W-1:0] LAST_R2 = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] LAST_R4 = CNT_W'(((WIDTH + 1) / 2) - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mode_q, mode_d;
    logic [CNT_W-1:0] last_cnt;
    logic             accept_ok;

    // Registered state, iteration counter and latched radix mode.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
        end
    end

    // Next-state logic and strobe decode; abort overrides every transition.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mode_d      = mode_q;
        load_en     = 1'b0;
        step_en     = 1'b0;
        first_round = 1'b0;
        last_round  = 1'b0;
        iter_idx    = '0;
        out_valid   = 1'b0;

        last_cnt  = mode_q ? LAST_R4 : LAST_R2;
        // A new op may enter from IDLE, or from DONE in the same cycle the
        // consumer takes the old result.
        accept_ok = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
        start_ack = start && !abort && accept_ok;

        case (state_q)
            S_IDLE: begin
                if (start_ack) begin
                    state_d = S_LOAD;
                    mode_d  = radix4;
                    cnt_d   = '0;
                end
            end
            S_LOAD: begin
                load_en = 1'b1;
                state_d = S_RUN;
            end
            S_RUN: begin
                step_en     = 1'b1;
                iter_idx    = cnt_q;
                first_round = (cnt_q == '0);
                last_round  = (cnt_q == last_cnt);
                if (cnt_q == last_cnt) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (start_ack) begin
                    state_d = S_LOAD;
                    mode_d  = radix4;
                    cnt_d   = '0;
                end else if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        if (abort) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end
    end

    assign mode_r4 = mode_q;
    assign busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_booth_seq_controller.sv
// tb/tb_booth_seq_controller.sv - self-checking bench for booth_seq_controller
module tb_booth_seq_controller;

    localparam int W   = 8;
    localparam int CW  = $clog2(W + 1);
    localparam int W7  = 7;
    localparam int CW7 = $clog2(W7 + 1);

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0, radix4 = 1'b0, abort = 1'b0, out_ready = 1'b0;

    logic          start_ack, load_en, step_en, first_round, last_round, mode_r4, busy, out_valid;
    logic [CW-1:0] iter_idx;

    logic           sa7, ld7, st7, fr7, lr7, m7, b7, v7;
    logic [CW7-1:0] idx7;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    booth_seq_controller #(.WIDTH(W)) u_dut (
        .clk(clk), .rst(rst), .start(start), .radix4(radix4), .abort(abort),
        .out_ready(out_ready), .start_ack(start_ack), .load_en(load_en),
        .step_en(step_en), .first_round(first_round), .last_round(last_round),
        .iter_idx(iter_idx), .mode_r4(mode_r4), .busy(busy), .out_valid(out_valid)
    );

    booth_seq_controller #(.WIDTH(W7)) u_dut7 (
        .clk(clk), .rst(rst), .start(start), .radix4(radix4), .abort(abort),
        .out_ready(out_ready), .start_ack(sa7), .load_en(ld7),
        .step_en(st7), .first_round(fr7), .last_round(lr7),
        .iter_idx(idx7), .mode_r4(m7), .busy(b7), .out_valid(v7)
    );

    // Reference model: an op is a timeline anchored at its accept cycle t0.
    // Offset 1 is the load, offsets 2..N+1 are steps, N+2 onward is result-valid.
    int      cyc;
    bit      m_active;
    int      m_t0;
    int      m_n;
    bit      m_mode;
    int      k;
    logic    e_ack, e_ld, e_st, e_fr, e_lr, e_vl, e_busy;
    logic [CW-1:0] e_idx;

    always_comb begin
        k      = cyc - m_t0;
        e_ld   = m_active && (k == 1);
        e_st   = m_active && (k >= 2) && (k <= m_n + 1);
        e_fr   = m_active && (k == 2);
        e_lr   = m_active && (k == m_n + 1);
        e_idx  = e_st ? CW'(k - 2) : '0;
        e_vl   = m_active && (k >= m_n + 2);
        e_busy = m_active;
        e_ack  = start && !abort && (!m_active || (e_vl && out_ready));
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_active <= 1'b0;
            m_mode   <= 1'b0;
            m_t0     <= 0;
            m_n      <= W;
            cyc      <= 0;
        end else begin
            cyc <= cyc + 1;
            if (abort) begin
                m_active <= 1'b0;
            end else if (e_ack) begin
                m_active <= 1'b1;
                m_t0     <= cyc;
                m_n      <= radix4 ? (W + 1) / 2 : W;
                m_mode   <= radix4;
            end else if (e_vl && out_ready) begin
                m_active <= 1'b0;
            end
        end
    end

    task automatic do_reset();
        rst = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b0; radix4 = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic test_reset();
        logic [CW+6:0] act;
        rst = 1'b0; start = 1'b1; radix4 = 1'b1; abort = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (start_ack !== 1'b1) begin n_bad++; $display("FAIL reset_ack: got %b want 1", start_ack); end
        act = {load_en, step_en, first_round, last_round, iter_idx, mode_r4, busy, out_valid};
        n_cmp++;
        if (act !== '0) begin n_bad++; $display("FAIL reset_outs: got %h want 0", act); end
        abort = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (start_ack !== 1'b0) begin n_bad++; $display("FAIL reset_abort_ack: got %b want 0", start_ack); end
        start = 1'b0; abort = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({busy, out_valid} !== 2'b00) begin n_bad++; $display("FAIL reset_release: busy/valid=%b want 00", {busy, out_valid}); end
        // Reset asserted mid-RUN must clear the op without waiting for a clock edge.
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        n_cmp++;
        if ({busy, step_en, mode_r4} !== 3'b000) begin n_bad++; $display("FAIL reset_midop: busy/step/mode=%b want 000", {busy, step_en, mode_r4}); end
        @(posedge clk); #1 rst = 1'b1;
    endtask

    task automatic test_timeline(input bit rdx, input int n);
        logic [CW+6:0]  act, exp_v;
        logic [CW7+6:0] act7, exp7;
        int steps;
        bit x_ld, x_st, x_fr, x_lr, x_vl;
        int x_ix;
        do_reset();
        start = 1'b1; radix4 = rdx;
        @(negedge clk);
        n_cmp++;
        if (start_ack !== 1'b1) begin n_bad++; $display("FAIL timeline_ack r4=%0d: got %b want 1", rdx, start_ack); end
        @(posedge clk); #1 start = 1'b0; radix4 = !rdx;
        steps = 0;
        for (int c = 1; c <= n + 3; c++) begin
            @(negedge clk);
            x_ld = (c == 1);
            x_st = (c >= 2) && (c <= n + 1);
            x_fr = (c == 2);
            x_lr = (c == n + 1);
            x_ix = x_st ? c - 2 : 0;
            x_vl = (c >= n + 2);
            steps += int'(step_en);
            act   = {load_en, step_en, first_round, last_round, iter_idx, mode_r4, busy, out_valid};
            exp_v = {x_ld, x_st, x_fr, x_lr, CW'(x_ix), rdx, 1'b1, x_vl};
            n_cmp++;
            if (act !== exp_v) begin n_bad++; $display("FAIL timeline r4=%0d c=%0d: got %h want %h", rdx, c, act, exp_v); end
            if (rdx) begin
                act7 = {ld7, st7, fr7, lr7, idx7, m7, b7, v7};
                exp7 = {x_ld, x_st, x_fr, x_lr, CW7'(x_ix), 1'b1, 1'b1, x_vl};
                n_cmp++;
                if (act7 !== exp7) begin n_bad++; $display("FAIL timeline_w7 c=%0d: got %h want %h", c, act7, exp7); end
            end
            @(posedge clk); #1;
        end
        n_cmp++;
        if (steps != n) begin n_bad++; $display("FAIL timeline_steps r4=%0d: got %0d want %0d", rdx, steps, n); end
        out_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({out_valid, start_ack} !== 2'b10) begin n_bad++; $display("FAIL timeline_handoff: valid/ack=%b want 10", {out_valid, start_ack}); end
        @(posedge clk); #1 out_ready = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({busy, out_valid} !== 2'b00) begin n_bad++; $display("FAIL timeline_idle: busy/valid=%b want 00", {busy, out_valid}); end
    endtask

    task automatic test_backpressure();
        bit seen;
        do_reset();
        start = 1'b1; radix4 = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = out_valid;
            @(posedge clk); #1;
        end
        n_cmp++;
        if (!seen) begin n_bad++; $display("FAIL bp_timeout: out_valid never rose within 20 cycles"); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({out_valid, step_en, load_en} !== 3'b100) begin
                n_bad++; $display("FAIL bp_hold i=%0d: valid/step/load=%b want 100", i, {out_valid, step_en, load_en});
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1 out_ready = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({busy, out_valid} !== 2'b00) begin n_bad++; $display("FAIL bp_release: busy/valid=%b want 00", {busy, out_valid}); end
    endtask

    task automatic test_abort();
        logic [CW+2:0] act, exp_v;
        do_reset();
        start = 1'b1; radix4 = 1'b0;
        @(posedge clk); #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #1 abort = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({step_en, iter_idx} !== {1'b1, CW'(2)}) begin n_bad++; $display("FAIL abort_at_step: step/idx=%h want 3rd step idx 2", {step_en, iter_idx}); end
        @(posedge clk); #1 abort = 1'b0; start = 1'b1; radix4 = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({busy, out_valid, step_en, load_en, start_ack} !== 5'b00001) begin
            n_bad++; $display("FAIL abort_idle: busy/valid/step/load/ack=%b want 00001", {busy, out_valid, step_en, load_en, start_ack});
        end
        @(posedge clk); #1 start = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            act   = {load_en, step_en, iter_idx, out_valid};
            exp_v = {c == 1, (c >= 2) && (c <= 5), ((c >= 2) && (c <= 5)) ? CW'(c - 2) : CW'(0), c == 6};
            n_cmp++;
            if (act !== exp_v) begin n_bad++; $display("FAIL abort_fresh c=%0d: got %h want %h", c, act, exp_v); end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1 out_ready = 1'b0; start = 1'b1; abort = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (start_ack !== 1'b0) begin n_bad++; $display("FAIL abort_start_ack: got %b want 0", start_ack); end
        @(posedge clk); #1 start = 1'b0; abort = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_start_busy: got %b want 0", busy); end
    endtask

    task automatic test_back_to_back();
        int  steps;
        bit  seen;
        do_reset();
        start = 1'b1; radix4 = 1'b0;
        @(posedge clk); #1 start = 1'b0;
        steps = 0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk); steps += int'(step_en);
            @(posedge clk); #1;
        end
        start = 1'b1; radix4 = 1'b1;
        @(negedge clk);
        steps += int'(step_en);
        n_cmp++;
        if (start_ack !== 1'b0) begin n_bad++; $display("FAIL b2b_midrun_ack: got %b want 0", start_ack); end
        @(posedge clk); #1 start = 1'b0; radix4 = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = out_valid;
            steps += int'(step_en);
            @(posedge clk); #1;
        end
        n_cmp++;
        if (!seen || steps != W || mode_r4 !== 1'b0) begin
            n_bad++; $display("FAIL b2b_first_op: seen=%0d steps=%0d mode=%b want 1 %0d 0", seen, steps, mode_r4, W);
        end
        out_ready = 1'b1; start = 1'b1; radix4 = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({out_valid, start_ack} !== 2'b11) begin n_bad++; $display("FAIL b2b_ack: valid/ack=%b want 11", {out_valid, start_ack}); end
        @(posedge clk); #1 start = 1'b0; out_ready = 1'b0; radix4 = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({load_en, mode_r4, out_valid} !== 3'b110) begin n_bad++; $display("FAIL b2b_load: load/mode/valid=%b want 110", {load_en, mode_r4, out_valid}); end
        @(posedge clk); #1;
        steps = 0; seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = out_valid;
            steps += int'(step_en);
            @(posedge clk); #1;
        end
        n_cmp++;
        if (!seen || steps != (W + 1) / 2) begin n_bad++; $display("FAIL b2b_second_op: seen=%0d steps=%0d want 1 %0d", seen, steps, (W + 1) / 2); end
        out_ready = 1'b1;
        @(posedge clk); #1 out_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [CW+7:0] act, exp_v;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            start     = ($urandom_range(0, 2) == 0);
            abort     = ($urandom_range(0, 24) == 0);
            out_ready = ($urandom_range(0, 1) == 1);
            radix4    = ($urandom_range(0, 1) == 1);
            @(negedge clk);
            act   = {start_ack, load_en, step_en, first_round, last_round, iter_idx, mode_r4, busy, out_valid};
            exp_v = {e_ack, e_ld, e_st, e_fr, e_lr, e_idx, m_mode, e_busy, e_vl};
            n_cmp++;
            if (act !== exp_v) begin n_bad++; $display("FAIL random cyc=%0d: got %h want %h", i, act, exp_v); end
            @(posedge clk); #1;
        end
        start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_timeline(1'b0, W);
        test_timeline(1'b1, (W + 1) / 2);
        test_backpressure();
        test_abort();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
